// File: rtl/key_debounce_if.sv
// -----------------------------------------------------------------------------
// key_debounce_if
// Purpose : groups the key-side signals of key_debounce_ctrl into one bundle.
// Signals : key_in      raw mechanical key, asynchronous, 0 = pressed
//           key_state   debounced key level, 1 = pressed
//           key_press   one-cycle pulse on each debounced press
//           key_release one-cycle pulse on each debounced release
//           key_long    one-cycle pulse on a long press
// Modports: master drives key_in and observes the debouncer outputs;
//           slave is the debouncer side.
// -----------------------------------------------------------------------------
interface key_debounce_if;
   logic key_in;
   logic key_state;
   logic key_press;
   logic key_release;
   logic key_long;

   modport master (
      output key_in,
      input  key_state,
      input  key_press,
      input  key_release,
      input  key_long
   );

   modport slave (
      input  key_in,
      output key_state,
      output key_press,
      output key_release,
      output key_long
   );
endinterface

// File: rtl/key_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// key_debounce_ctrl
// Purpose : debounces a mechanical key and reports its level plus press,
//           release and (optionally) long-press pulses.
// Ports   : clk        system clock
//           sys_rst_n  asynchronous active-low reset
//           key_if     key_debounce_if.slave (key_in in, key_state /
//                      key_press / key_release / key_long out)
// Params  : CNT_MAX    debounce window in clk cycles (>= 2)
//           LONG_MAX   long-press threshold in clk cycles (> CNT_MAX)
// Options : define KEY_LONG_PRESS_EN to build the long-press counter;
//           otherwise key_long is tied low.
// -----------------------------------------------------------------------------
module key_debounce_ctrl #(
   parameter int CNT_MAX  = 1_000_000,
   parameter int LONG_MAX = 50_000_000
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   key_debounce_if.slave key_if
);

   localparam int            CW       = $clog2(LONG_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

   typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} state_t;

   // Increment that sticks at lim instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                             input logic [CW-1:0] lim);
      return (v >= lim) ? lim : v + CW'(1);
   endfunction

   // Synchronizer resets to the released level so a held key after reset
   // is seen as a fresh falling edge and gets a full press filter.
   logic sync1_q;
   logic sync2_q;
   logic key_sync;

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_if.key_in;
         sync2_q <= sync1_q;
      end
   end

   assign key_sync = sync2_q;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          key_state_q, key_state_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         key_state_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_state_q <= key_state_d;
         press_q     <= press_d;
         release_q   <= release_d;
      end
   end

   // The counter is cleared in every state that does not filter, so each
   // filter run starts from zero. The final sample (cnt_q == CNT_MAX-1 plus
   // the current one) completes CNT_MAX consecutive samples.
   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      key_state_d = key_state_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!key_sync) state_d = PRESS_FILT;
         end
         PRESS_FILT: begin
            if (key_sync) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = DOWN;
               press_d     = 1'b1;
               key_state_d = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q, CNT_SAT);
            end
         end
         DOWN: begin
            if (key_sync) state_d = REL_FILT;
         end
         REL_FILT: begin
            if (!key_sync) begin
               state_d = DOWN;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = IDLE;
               release_d   = 1'b1;
               key_state_d = 1'b0;
            end else begin
               cnt_d = sat_inc(cnt_q, CNT_SAT);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign key_if.key_state   = key_state_q;
   assign key_if.key_press   = press_q;
   assign key_if.key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MAX - 1);
   localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_MAX);

   logic [CW-1:0] long_cnt_q, long_cnt_d;
   logic          long_q, long_d;

   // Cleared only on a real press, so a release bounce that returns to DOWN
   // keeps the accumulated hold time. Saturation at LONG_MAX means the
   // threshold is crossed exactly once per press.
   always_comb begin
      long_cnt_d = long_cnt_q;
      long_d     = 1'b0;
      if ((state_q == PRESS_FILT) && (state_d == DOWN)) begin
         long_cnt_d = '0;
      end else if (state_q == DOWN) begin
         long_cnt_d = sat_inc(long_cnt_q, LONG_SAT);
         long_d     = (long_cnt_q == LONG_LAST);
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         long_cnt_q <= long_cnt_d;
         long_q     <= long_d;
      end
   end

   assign key_if.key_long = long_q;
`else
   assign key_if.key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_ctrl
// Purpose : self-checking bench for key_debounce_ctrl (CNT_MAX=8, LONG_MAX=40).
//           Expected pulses are queued with the cycle they must appear in;
//           a negedge monitor pops and compares them and tracks key_state.
// -----------------------------------------------------------------------------
module tb_key_debounce_ctrl;

   localparam int         CNT_MAX  = 8;
   localparam int         LONG_MAX = 40;
   localparam int         LAT      = CNT_MAX + 3;
   localparam logic [2:0] EV_PRESS = 3'b001;
   localparam logic [2:0] EV_REL   = 3'b010;
   localparam logic [2:0] EV_LONG  = 3'b100;

   logic clk = 1'b0;
   logic sys_rst_n;

   key_debounce_if key_if ();

   key_debounce_ctrl #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
   ) dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .key_if    (key_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [2:0] kind;
   } ev_t;

   ev_t  sb_q[$];
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_errors  = 0;
   logic exp_state = 1'b0;
   logic [2:0] mon_obs;
   ev_t  mon_ev;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input logic [2:0] kind, input int at);
      ev_t e;
      e.cyc  = at;
      e.kind = kind;
      sb_q.push_back(e);
   endtask

   function automatic logic [3:0] outs();
      return {key_if.key_state, key_if.key_long, key_if.key_release, key_if.key_press};
   endfunction

   task automatic reset_pulse(input string tag, input int hold);
      sys_rst_n = 1'b0;
      sb_q.delete();
      exp_state = 1'b0;
      #1;
      check(tag, int'(outs()), 0);
      tick(hold);
      sys_rst_n = 1'b1;
   endtask

   // Monitor: every cycle either the queued pulse is due, or no pulse at all.
   always @(negedge clk) begin
      mon_obs = {key_if.key_long, key_if.key_release, key_if.key_press};
      if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
         mon_ev = sb_q.pop_front();
         check("pulse", int'(mon_obs), int'(mon_ev.kind));
         if (mon_ev.kind == EV_PRESS) exp_state = 1'b1;
         else if (mon_ev.kind == EV_REL) exp_state = 1'b0;
      end else if (mon_obs != 3'b000) begin
         check("spurious_pulse", int'(mon_obs), 0);
      end
      check("key_state", int'(key_if.key_state), int'(exp_state));
   end

   initial begin
      int p;
      sys_rst_n     = 1'b0;
      key_if.key_in = 1'b1;
      tick(3);
      check("reset_state", int'(outs()), 0);
      sys_rst_n = 1'b1;
      tick(5);

      // Clean press, release bounce inside DOWN, clean release.
      key_if.key_in = 1'b0;
      expect_ev(EV_PRESS, cyc + LAT);
      tick(15);
      key_if.key_in = 1'b1;
      tick(4);
      key_if.key_in = 1'b0;
      tick(15);
      key_if.key_in = 1'b1;
      expect_ev(EV_REL, cyc + LAT);
      tick(20);

      // Press bounce: 5 low, 3 high, then held low.
      key_if.key_in = 1'b0;
      tick(5);
      key_if.key_in = 1'b1;
      tick(3);
      key_if.key_in = 1'b0;
      expect_ev(EV_PRESS, cyc + LAT);
      tick(20);
      key_if.key_in = 1'b1;
      expect_ev(EV_REL, cyc + LAT);
      tick(20);

      // Reset during PRESS_FILT, key still held afterwards.
      key_if.key_in = 1'b0;
      expect_ev(EV_PRESS, cyc + LAT);
      tick(6);
      reset_pulse("reset_mid_filter", 3);
      expect_ev(EV_PRESS, cyc + LAT);
      tick(15);

      // Reset while in DOWN, key still held afterwards.
      reset_pulse("reset_in_down", 2);
      expect_ev(EV_PRESS, cyc + LAT);
      tick(15);
      key_if.key_in = 1'b1;
      expect_ev(EV_REL, cyc + LAT);
      tick(20);

      // Long press: held 60 cycles past key_press.
      key_if.key_in = 1'b0;
      p = cyc + LAT;
      expect_ev(EV_PRESS, p);
`ifdef KEY_LONG_PRESS_EN
      expect_ev(EV_LONG, p + LONG_MAX);
`endif
      while (cyc < p + 60) tick(1);
      key_if.key_in = 1'b1;
      expect_ev(EV_REL, cyc + LAT);
      tick(20);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/key_debounce_ctrl.md
KEY_DEBOUNCE_CTRL -- requirements
Module: key_debounce_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 1_000_000, meaning the debounce window in clk cycles (20 ms at 50 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter LONG_MAX, default 50_000_000, meaning the long-press threshold in clk cycles (1 s at 50 MHz); legal range > CNT_MAX.
REQ-003 Port clk, input, 1 bit: system clock, 50 MHz.
REQ-004 Port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port key_in, input, 1 bit: raw mechanical key, asynchronous to clk, 0 = pressed.
REQ-006 Port key_state, output, 1 bit: debounced key level, 1 = pressed.
REQ-007 Port key_press, output, 1 bit: single-cycle pulse on each debounced press.
REQ-008 Port key_release, output, 1 bit: single-cycle pulse on each debounced release.
REQ-009 Port key_long, output, 1 bit: single-cycle pulse on long press (see Configuration).

Function
REQ-010 key_in SHALL pass through a 2-FF synchronizer to produce key_sync; no other logic SHALL sample key_in.
REQ-011 The block SHALL implement an FSM with states IDLE, PRESS_FILT, DOWN and REL_FILT.
REQ-012 IDLE: key_sync=0 -> PRESS_FILT with the debounce counter cleared; otherwise stay in IDLE.
REQ-013 PRESS_FILT: the counter SHALL increment while key_sync=0; key_sync=1 -> IDLE with the counter cleared (bounce rejected, no pulse).
REQ-014 PRESS_FILT: after CNT_MAX consecutive key_sync=0 samples -> DOWN; key_press=1 for exactly the first DOWN cycle; key_state=1 from that cycle on.
REQ-015 DOWN: key_sync=1 -> REL_FILT with the counter cleared.
REQ-016 REL_FILT: the counter SHALL increment while key_sync=1; key_sync=0 -> DOWN with the counter cleared, key_state held at 1, no pulse.
REQ-017 REL_FILT: after CNT_MAX consecutive key_sync=1 samples -> IDLE; key_release=1 for exactly the first IDLE cycle; key_state=0 from that cycle on.
REQ-018 All outputs SHALL be registered.
REQ-019 Latency from a clean key_in edge to key_press or key_release SHALL be exactly CNT_MAX+3 clk cycles.
REQ-020 The counter width SHALL be $clog2(LONG_MAX+1) bits; the counter SHALL saturate and never wrap.
REQ-021 key_press, key_release and key_long SHALL be mutually exclusive in any cycle.
REQ-022 key_state SHALL change only in the same cycle as a key_press or key_release pulse.

Reset
REQ-023 When sys_rst_n=0, asynchronously: FSM=IDLE; counters=0; synchronizer FFs=1 (released); key_state, key_press, key_release, key_long=0.
REQ-024 Reset asserted mid-filter or in DOWN SHALL abort without emitting any pulse.
REQ-025 After reset release with the key held low, the block SHALL perform a full press filter and then pulse key_press.

Configuration
REQ-026 With macro KEY_LONG_PRESS_EN defined: in DOWN, a long counter SHALL count cycles.
REQ-027 With KEY_LONG_PRESS_EN defined: when the long counter reaches LONG_MAX, key_long SHALL pulse once per press with no repeat.
REQ-028 With KEY_LONG_PRESS_EN defined: the long counter SHALL clear on entering DOWN from PRESS_FILT only; a bounce into REL_FILT and back to DOWN SHALL NOT clear it.
REQ-029 With KEY_LONG_PRESS_EN undefined: key_long SHALL be tied to 0 and no long-counter logic SHALL be synthesized.

Verification
REQ-030 Bench SHALL use CNT_MAX=8 and LONG_MAX=40.
REQ-031 Clean press: key_in 1->0 and held -> key_press high for 1 cycle exactly 11 cycles later; key_state=1 in the same cycle.
REQ-032 Bounce: key_in low for 5 cycles, high for 3, then low and held -> exactly one key_press, 11 cycles after the final falling edge.
REQ-033 Release bounce: from DOWN, key_in high for 4 cycles then low -> no key_release, and key_state stays 1 throughout.
REQ-034 Reset mid-operation: sys_rst_n pulsed low during PRESS_FILT -> all outputs 0 immediately; key_press appears 11 cycles after reset release if the key is still held.
REQ-035 Long press with KEY_LONG_PRESS_EN defined: key held 60 cycles past key_press -> one key_long pulse 40 cycles after key_press, and none before key_release. With the macro undefined, key_long=0 throughout.
